// File: rtl/text_buffer_writer.sv
// rtl/text_buffer_writer.sv - character-cell text buffer with cursor, control codes, wrap and scroll
module text_buffer_writer #(
    parameter int COLS = 32,
    parameter int ROWS = 4,
    parameter int X0   = 192,
    parameter int Y0   = 208,
    localparam int CW  = $clog2(COLS),
    localparam int RW  = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [6:0]    char_in,
    input  logic          char_valid,
    output logic          char_ready,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    output logic [6:0]    ascii_char,
    output logic [CW-1:0] cursor_col,
    output logic [RW-1:0] cursor_row
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = CW + RW;

    localparam logic [6:0]    SPACE       = 7'h20;
    localparam logic [AW-1:0] CLEAR_LAST  = AW'(CELLS - 1);
    localparam logic [AW-1:0] SCROLL_LAST = AW'((ROWS - 1) * COLS);
    localparam logic [AW-1:0] BLANK_LAST  = AW'(COLS - 1);
    localparam logic [CW-1:0] COL_MAX     = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX     = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_SCROLL,
        S_BLANK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;

    logic [6:0]    mem_q [CELLS];
    logic [6:0]    scroll_q;
    logic [6:0]    ascii_q;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [AW-1:0] scroll_addr;
    logic          accept;
    logic          printable;
    logic          adv_row;

    logic          in_win;
    logic [9:0]    x_off;
    logic [9:0]    y_off;
    logic [AW-1:0] disp_addr;

    // ready is only ever high in IDLE, so it alone qualifies an accept
    assign accept    = ready_q && char_valid;
    assign printable = (char_in >= 7'h20) && (char_in != 7'h7F);

    // Scroll reads run one cell ahead of the write, so the source is always one row down
    assign scroll_addr = cnt_q + AW'(COLS);

    // Pixel-to-cell mapping for the display port
    assign in_win = ({1'b0, x} >= 11'(X0)) && ({1'b0, x} < 11'(X0 + 8 * COLS)) &&
                    ({1'b0, y} >= 11'(Y0)) && ({1'b0, y} < 11'(Y0 + 16 * ROWS));
    assign x_off     = x - 10'(X0);
    assign y_off     = y - 10'(Y0);
    assign disp_addr = {RW'(y_off >> 4), CW'(x_off >> 3)};

    // Next-state, cursor and write-port decode
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_data = SPACE;
        adv_row = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                if (cnt_q == CLEAR_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_IDLE: begin
                if (accept) begin
                    if (printable) begin
                        wr_en   = 1'b1;
                        wr_addr = {row_q, col_q};
                        wr_data = char_in;
                        if (col_q == COL_MAX) begin
                            col_d   = '0;
                            adv_row = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else if (char_in == 7'h0A || char_in == 7'h0D) begin
                        col_d   = '0;
                        adv_row = 1'b1;
                    end else if (char_in == 7'h08) begin
                        // No reverse wrap: backspace at column 0 does nothing
                        if (col_q != '0) begin
                            col_d   = col_q - 1'b1;
                            wr_en   = 1'b1;
                            wr_addr = {row_q, col_q - 1'b1};
                        end
                    end else if (char_in == 7'h0C) begin
                        col_d   = '0;
                        row_d   = '0;
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        state_d = S_CLEAR;
                    end
                end
            end

            S_SCROLL: begin
                // Count 0 only primes the scroll read; writes lag the reads by one cell
                wr_en   = (cnt_q != '0);
                wr_addr = cnt_q - 1'b1;
                wr_data = scroll_q;
                if (cnt_q == SCROLL_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_BLANK: begin
                wr_en   = 1'b1;
                wr_addr = {ROW_MAX, CW'(cnt_q)};
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase

        // Row advance from a wrap or newline; the bottom row scrolls instead
        if (adv_row) begin
            if (row_q == ROW_MAX) begin
                state_d = S_SCROLL;
                ready_d = 1'b0;
                cnt_d   = '0;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    // FSM state, cursor, sequencing counter and handshake register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Buffer write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Scroll read port, free-running; only consumed while scrolling
    always_ff @(posedge clk) begin
        scroll_q <= mem_q[scroll_addr];
    end

    // Display read port; a same-cycle write to the cell is seen next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ascii_q <= SPACE;
        end else begin
            ascii_q <= in_win ? mem_q[disp_addr] : SPACE;
        end
    end

    assign char_ready = ready_q;
    assign ascii_char = ascii_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// tb/tb_text_buffer_writer.sv - self-checking bench for text_buffer_writer
module tb_text_buffer_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] char_in = 7'h00;
    logic       char_valid = 1'b0;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       char_ready;
    logic [6:0] ascii_char;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;

    int n_tests = 0;
    int n_fail  = 0;

    text_buffer_writer #(.COLS(32), .ROWS(4), .X0(192), .Y0(208)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .x          (x),
        .y          (y),
        .ascii_char (ascii_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Screen model: a 4x32 character grid, a cursor, and the number of
    // cycles the writer stays unavailable after a clear or scroll.
    logic [6:0] mm [128];
    int         m_col;
    int         m_row;
    int         m_busy;
    logic [6:0] exp_ascii;
    bit         exp_valid;

    task automatic m_clear();
        for (int i = 0; i < 128; i++) mm[i] = 7'h20;
        m_col  = 0;
        m_row  = 0;
        m_busy = 128;
    endtask

    task automatic m_newline();
        m_col = 0;
        if (m_row == 3) begin
            for (int i = 0; i < 96; i++) mm[i] = mm[i + 32];
            for (int i = 96; i < 128; i++) mm[i] = 7'h20;
            m_busy = (3 * 32 + 1) + 32;
        end else begin
            m_row++;
        end
    endtask

    task automatic m_accept(input logic [6:0] c);
        if (c >= 7'h20 && c != 7'h7F) begin
            mm[m_row * 32 + m_col] = c;
            if (m_col == 31) m_newline();
            else m_col++;
        end else if (c == 7'h0A || c == 7'h0D) begin
            m_newline();
        end else if (c == 7'h08) begin
            if (m_col > 0) begin
                m_col--;
                mm[m_row * 32 + m_col] = 7'h20;
            end
        end else if (c == 7'h0C) begin
            m_clear();
        end
    endtask

    function automatic logic [6:0] win_lookup(input logic [9:0] px, input logic [9:0] py);
        int ix = int'(px);
        int iy = int'(py);
        if (ix >= 192 && ix < 192 + 256 && iy >= 208 && iy < 208 + 64)
            return mm[((iy - 208) / 16) * 32 + (ix - 192) / 8];
        return 7'h20;
    endfunction

    // Advance the model on every edge and compare all outputs just after it
    always @(posedge clk) begin
        if (reset) begin
            m_clear();
            exp_valid = 1'b1;
            exp_ascii = 7'h20;
        end else begin
            exp_valid = (m_busy == 0);
            exp_ascii = win_lookup(x, y);
            if (m_busy > 0) m_busy--;
            else if (char_valid) m_accept(char_in);
        end
        #1;
        check("ready", char_ready, (m_busy == 0 && !reset));
        check("cursor_col", cursor_col, m_col);
        check("cursor_row", cursor_row, m_row);
        if (exp_valid) check("ascii", ascii_char, exp_ascii);
    end

    // Stimulus helpers; all are entered and left at a falling edge
    task automatic send_char(input logic [6:0] c);
        int guard = 0;
        char_in    = c;
        char_valid = 1'b1;
        while (!char_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 for char %0h", c);
        end
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!char_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_cell(input int r, input int c, output logic [6:0] v);
        x = 10'(192 + 8 * c + 3);
        y = 10'(208 + 16 * r + 5);
        @(negedge clk);
        v = ascii_char;
    endtask

    task automatic sweep_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++) begin
                x = 10'(192 + 8 * c + (c % 8));
                y = 10'(208 + 16 * r + (r * 5));
                @(negedge clk);
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [6:0] v;
        int         xs [4] = '{191, 192, 447, 448};
        int         ys [4] = '{207, 208, 271, 272};

        // Reset and initial clear
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", char_ready, 1'b0);
        check("rst_ascii", ascii_char, 7'h20);
        check("rst_cursor", {cursor_row, cursor_col}, 7'd0);
        reset = 1'b0;
        count_low(n);
        check("clear_cycles", n, 128);
        sweep_all();
        foreach (xs[i]) foreach (ys[j]) begin
            x = 10'(xs[i]);
            y = 10'(ys[j]);
            @(negedge clk);
        end
        check("init_cursor", {cursor_row, cursor_col}, 7'd0);

        // Single printable at the origin
        send_char(7'h41);
        x = 10'd192;
        y = 10'd208;
        @(negedge clk);
        check("first_char", ascii_char, 7'h41);
        check("first_col", cursor_col, 5'd1);
        check("first_ready", char_ready, 1'b1);

        // 33 back-to-back printables wrap into row 1
        send_char(7'h0C);
        count_low(n);
        check("ff_cycles", n, 128);
        for (int k = 1; k <= 33; k++) send_char(7'(8'h30 + k));
        read_cell(0, 31, v);
        check("wrap_c31", v, 7'h50);
        read_cell(1, 0, v);
        check("wrap_r1c0", v, 7'h51);
        check("wrap_cursor", {cursor_row, cursor_col}, {2'd1, 5'd1});
        x = 10'd100;
        y = 10'd210;
        @(negedge clk);
        check("out_window", ascii_char, 7'h20);

        // Fill rows, newline on the bottom row scrolls
        send_char(7'h0C);
        count_low(n);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 32; c++) send_char(7'(8'h41 + r));
        for (int c = 0; c < 5; c++) send_char(7'h44);
        check("fill_cursor", {cursor_row, cursor_col}, {2'd3, 5'd5});
        send_char(7'h0A);
        count_low(n);
        check("scroll_cycles", n, 129);
        read_cell(0, 0, v);
        check("scr_r0c0", v, 7'h42);
        read_cell(1, 17, v);
        check("scr_r1c17", v, 7'h43);
        read_cell(2, 4, v);
        check("scr_r2c4", v, 7'h44);
        read_cell(2, 5, v);
        check("scr_r2c5", v, 7'h20);
        read_cell(3, 10, v);
        check("scr_r3c10", v, 7'h20);
        check("scr_cursor", {cursor_row, cursor_col}, {2'd3, 5'd0});
        sweep_all();

        // Backspace, form feed, discarded codes, carriage return
        send_char(7'h0C);
        count_low(n);
        for (int c = 0; c < 64; c++) send_char(7'h4D);
        send_char(7'h08);
        check("bs0_cursor", {cursor_row, cursor_col}, {2'd2, 5'd0});
        read_cell(1, 31, v);
        check("bs0_prev", v, 7'h4D);
        send_char(7'h57);
        send_char(7'h58);
        send_char(7'h59);
        send_char(7'h5A);
        send_char(7'h08);
        check("bs_cursor", {cursor_row, cursor_col}, {2'd2, 5'd3});
        read_cell(2, 3, v);
        check("bs_cell", v, 7'h20);
        read_cell(2, 2, v);
        check("bs_keep", v, 7'h59);
        send_char(7'h0C);
        count_low(n);
        check("ff2_cycles", n, 128);
        check("ff2_cursor", {cursor_row, cursor_col}, 7'd0);
        send_char(7'h51);
        send_char(7'h07);
        check("bel_ready", char_ready, 1'b1);
        send_char(7'h7F);
        check("del_cursor", {cursor_row, cursor_col}, {2'd0, 5'd1});
        send_char(7'h0D);
        check("cr_cursor", {cursor_row, cursor_col}, {2'd1, 5'd0});
        sweep_all();

        // Wrap on the last cell scrolls; then reset in the middle of a scroll
        send_char(7'h0C);
        count_low(n);
        for (int c = 0; c < 127; c++) send_char(7'h4B);
        send_char(7'h4C);
        count_low(n);
        check("wrapscr_cycles", n, 129);
        check("wrapscr_cursor", {cursor_row, cursor_col}, {2'd3, 5'd0});
        read_cell(2, 31, v);
        check("wrapscr_cell", v, 7'h4C);
        send_char(7'h0A);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ready", char_ready, 1'b0);
        check("midrst_ascii", ascii_char, 7'h20);
        check("midrst_cursor", {cursor_row, cursor_col}, 7'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        count_low(n);
        check("reclear_cycles", n, 128);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++) begin
                read_cell(r, c, v);
                check("reclear_cell", v, 7'h20);
            end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
Character-cell text buffer that sits upstream of the ASCII glyph renderer. It accepts a stream of ASCII codes over a valid/ready handshake, places them at a cursor, and handles control codes (newline, backspace, form feed), line wrap and scrolling. It also provides a display read port: given the pixel x/y, it returns the 7-bit ASCII code of the cell under that pixel, which feeds the renderer's ascii_char input.

Parameters:
COLS, 32, text columns (power of 2)
ROWS, 4, text rows (power of 2, >=2)
X0, 192, left pixel edge of the text window (cells are 8 px wide)
Y0, 208, top pixel edge of the text window (cells are 16 px tall)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
char_in  in  7  ASCII code offered by the producer
char_valid  in  1  char_in is valid
char_ready  out  1  block can accept a character this cycle
x  in  10  current pixel column from the VGA sync
y  in  10  current pixel row from the VGA sync
ascii_char  out  7  code of the cell under (x,y); 1-cycle registered
cursor_col  out  clog2(COLS)  current cursor column
cursor_row  out  clog2(ROWS)  current cursor row

Behaviour:
- Storage: COLS*ROWS x 7-bit array. Address = row*COLS + col. One write port and two synchronous read ports (display and scroll).
- Reset state: state=CLEAR, cursor 0,0, char_ready=0, ascii_char=7'h20, clear counter=0. Reset asserted in any state, including mid-scroll, aborts the operation and restarts CLEAR.
- States:
  - CLEAR: writes 7'h20 to one cell per cycle, from address 0 up to COLS*ROWS-1. Takes COLS*ROWS cycles, then goes to IDLE.
  - IDLE: char_ready=1. A character is accepted when char_valid&&char_ready, and is processed on that edge.
  - SCROLL: copies row r+1 into row r for r=0..ROWS-2, one cell per cycle, with a 1-cycle read prime. Takes (ROWS-1)*COLS+1 cycles, then goes to BLANK.
  - BLANK: writes 7'h20 across row ROWS-1 (COLS cycles), then goes to IDLE.
- char_ready=0 in CLEAR, SCROLL and BLANK.
- Accepted code handling:
  - 0x20-0x7E: write the code at the cursor, then col+1.
    - If col was COLS-1: col=0 and row+1.
    - If row was ROWS-1 on that wrap: row stays, and the block enters SCROLL.
  - 0x0A or 0x0D: col=0 and row+1. If row was ROWS-1: row stays, and the block enters SCROLL.
  - 0x08: if col>0, col-1 and write 7'h20 at the new col. At col 0 it is a no-op (no reverse wrap).
  - 0x0C: cursor 0,0 and enter CLEAR.
  - Other codes (<0x20, 0x7F): accepted and discarded; no state change.
- A printable write in IDLE with no wrap-scroll keeps char_ready=1, giving back-to-back throughput of 1 char/cycle.
- Display port:
  - In-window test: X0<=x<X0+8*COLS and Y0<=y<Y0+16*ROWS.
  - Cell mapping: col=(x-X0)>>3, row=(y-Y0)>>4.
  - ascii_char = cell content, registered one cycle after x/y.
  - Outside the window, ascii_char=7'h20 (also registered).
  - The display read is independent of writer state. During SCROLL/BLANK the display shows intermediate content (acceptable).
- Simultaneous write and display read of the same cell: the display returns the old value that cycle.

Test Plan:
- Reset, then hold char_valid=0 -> char_ready rises exactly 128 cycles after reset deasserts. Sweeping the window returns ascii_char=7'h20 everywhere; cursor=0,0.
- Send 0x41 -> one cycle after x=192,y=208 is presented, ascii_char=7'h41. cursor_col=1. char_ready stays 1.
- Stream 33 printable chars from 0,0 -> cell (0,31) holds char 32, char 33 lands at (1,0), cursor=(1,1). Out-of-window x=100 gives 7'h20.
- Fill rows 0-3 with distinct letters, cursor at (3,5), send 0x0A -> char_ready low for 97+32=129 cycles. Afterwards row0 holds the old row1, row3 is all spaces, cursor=(3,0).
- Backspace at (2,0) leaves cursor (2,0) with contents unchanged. Backspace at (2,4) gives cursor (2,3) and cell (2,3)=7'h20. Send 0x0C -> 128-cycle clear, cursor 0,0. Send 0x07 -> no change, ready stays 1.
- Assert reset 40 cycles into SCROLL -> outputs return to reset values immediately. Full CLEAR runs, then the buffer is all 7'h20.
